// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage owning the PC; fetches over req/ack, hands instr/pc to ID, honours EX redirects.
// Optional FETCH_BUF_EN adds a one-entry fetch buffer so back-to-back fetches overlap ID stalls.
module if_fetch_unit #(
  parameter int DATA_SIZE = 32,
  parameter logic [DATA_SIZE-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 im_req,
  output logic [DATA_SIZE-1:0] im_addr,
  input  logic                 im_ack,
  input  logic [DATA_SIZE-1:0] im_rdata,
  input  logic                 redirect_valid,
  input  logic [DATA_SIZE-1:0] redirect_addr,
  input  logic                 id_stall,
  output logic                 if_valid,
  output logic [DATA_SIZE-1:0] if_pc,
  output logic [DATA_SIZE-1:0] if_next_pc,
  output logic [DATA_SIZE-1:0] if_instr,
  output logic                 fetch_busy
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, FLUSH} state_t;
  state_t state;
  logic [DATA_SIZE-1:0] pc_reg, saved, target, pc_inc;
  logic consume, unused_lo;
`ifdef FETCH_BUF_EN
  logic [DATA_SIZE-1:0] fb_instr, fb_pc;
`endif
  assign target     = {redirect_addr[DATA_SIZE-1:2], 2'b00};
  assign unused_lo  = ^redirect_addr[1:0];
  assign pc_inc     = pc_reg + DATA_SIZE'(4);
  assign consume    = if_valid && !id_stall;
  assign if_next_pc = if_pc + DATA_SIZE'(4);
  assign fetch_busy = im_req && !im_ack;
  // With the buffer enabled, HOLD means "buffer full": leaving HOLD empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc_reg   <= RESET_PC;
      saved    <= '0;
      im_req   <= 1'b0;
      im_addr  <= '0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
`ifdef FETCH_BUF_EN
      fb_instr <= '0;
      fb_pc    <= '0;
`endif
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
      if (state == FLUSH || (state == REQ && !im_ack)) begin
        saved <= target;
        state <= FLUSH;
      end else begin
        pc_reg  <= target;
        im_addr <= target;
        im_req  <= 1'b1;
        state   <= REQ;
      end
    end else begin
      case (state)
        IDLE: begin
          im_req  <= 1'b1;
          im_addr <= pc_reg;
          state   <= REQ;
        end
        REQ: begin
`ifdef FETCH_BUF_EN
          if (consume) if_valid <= 1'b0;
`endif
          if (im_ack) begin
            pc_reg <= pc_inc;
`ifdef FETCH_BUF_EN
            if (if_valid && id_stall) begin
              fb_instr <= im_rdata;
              fb_pc    <= pc_reg;
              im_req   <= 1'b0;
              state    <= HOLD;
            end else begin
              if_instr <= im_rdata;
              if_pc    <= pc_reg;
              if_valid <= 1'b1;
              im_addr  <= pc_inc;
            end
`else
            if_instr <= im_rdata;
            if_pc    <= pc_reg;
            if_valid <= 1'b1;
            im_req   <= 1'b0;
            state    <= HOLD;
`endif
          end
        end
        HOLD: if (consume) begin
`ifdef FETCH_BUF_EN
          if_instr <= fb_instr;
          if_pc    <= fb_pc;
`else
          if_valid <= 1'b0;
`endif
          im_req  <= 1'b1;
          im_addr <= pc_reg;
          state   <= REQ;
        end
        FLUSH: if (im_ack) begin
          pc_reg  <= saved;
          im_addr <= saved;
          state   <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed self-checking bench for if_fetch_unit (default serial-fetch build).
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        im_req, im_ack = 1'b0;
  logic [31:0] im_addr, im_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        id_stall = 1'b0;
  logic        if_valid, fetch_busy;
  logic [31:0] if_pc, if_next_pc, if_instr;
  int n_cmp = 0;
  int n_err = 0;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack),
    .im_rdata(im_rdata), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .id_stall(id_stall), .if_valid(if_valid), .if_pc(if_pc), .if_next_pc(if_next_pc),
    .if_instr(if_instr), .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack(input logic [31:0] data);
    im_ack = 1'b1;
    im_rdata = data;
    tick();
    im_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", im_req); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", if_valid); end
    n_cmp++; if (im_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", im_addr); end
    n_cmp++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin n_err++; $display("FAIL rst_out got pc %h instr %h want 0/0", if_pc, if_instr); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (im_req !== 1'b1 || im_addr !== 32'h0) begin n_err++; $display("FAIL first_req got %b/%h want 1/0", im_req, im_addr); end
    n_cmp++; if (fetch_busy !== 1'b1) begin n_err++; $display("FAIL busy got %b want 1", fetch_busy); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a = 32'(4 * i);
      n_cmp++; if (im_req !== 1'b1 || im_addr !== a) begin n_err++; $display("FAIL seq_req%0d got %b/%h want 1/%h", i, im_req, im_addr, a); end
      ack({16'hC0DE, a[15:0]});
      n_cmp++; if (if_valid !== 1'b1 || if_pc !== a || if_next_pc !== a + 32'd4) begin n_err++; $display("FAIL seq_out%0d got v%b pc %h npc %h want 1 %h %h", i, if_valid, if_pc, if_next_pc, a, a + 32'd4); end
      n_cmp++; if (if_instr !== {16'hC0DE, a[15:0]}) begin n_err++; $display("FAIL seq_instr%0d got %h want %h", i, if_instr, {16'hC0DE, a[15:0]}); end
      n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL seq_hold_req%0d got %b want 0", i, im_req); end
      tick();
      n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL seq_consume%0d got %b want 0", i, if_valid); end
    end
  endtask

  task automatic test_stall();
    id_stall = 1'b1;
    ack(32'h1111_0010);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_instr !== 32'h1111_0010) begin n_err++; $display("FAIL stall_hold%0d got v%b pc %h instr %h want 1 10 11110010", i, if_valid, if_pc, if_instr); end
      n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL stall_req%0d got %b want 0", i, im_req); end
    end
    id_stall = 1'b0;
    tick();
    n_cmp++; if (if_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h14) begin n_err++; $display("FAIL stall_release got v%b req %b addr %h want 0 1 14", if_valid, im_req, im_addr); end
  endtask

  task automatic test_redirect_flush();
    redirect_valid = 1'b1;
    redirect_addr = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (im_req !== 1'b1 || im_addr !== 32'h14 || if_valid !== 1'b0) begin n_err++; $display("FAIL flush_hold got req %b addr %h v%b want 1 14 0", im_req, im_addr, if_valid); end
    tick();
    tick();
    ack(32'hDEAD_BEEF);
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop got v%b want 0", if_valid); end
    n_cmp++; if (im_req !== 1'b1 || im_addr !== 32'h100) begin n_err++; $display("FAIL flush_target got %b/%h want 1/100", im_req, im_addr); end
    ack(32'h2222_0100);
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'h2222_0100) begin n_err++; $display("FAIL flush_fetch got v%b pc %h instr %h want 1 100 22220100", if_valid, if_pc, if_instr); end
    tick();
    n_cmp++; if (im_addr !== 32'h104) begin n_err++; $display("FAIL flush_next got %h want 104", im_addr); end
  endtask

  task automatic test_redirect_ack();
    redirect_valid = 1'b1;
    redirect_addr = 32'h0000_0200;
    ack(32'hBAD0_0104);
    redirect_valid = 1'b0;
    n_cmp++; if (if_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h200) begin n_err++; $display("FAIL rdack got v%b req %b addr %h want 0 1 200", if_valid, im_req, im_addr); end
    tick();
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rdack_stale got v%b want 0", if_valid); end
    ack(32'h3333_0200);
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== 32'h3333_0200) begin n_err++; $display("FAIL rdack_fetch got v%b pc %h instr %h want 1 200 33330200", if_valid, if_pc, if_instr); end
    tick();
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_addr = 32'hFFFF_FFFF;
    ack(32'h0);
    redirect_valid = 1'b0;
    n_cmp++; if (im_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr got %h want fffffffc", im_addr); end
    ack(32'h4444_FFFC);
    n_cmp++; if (if_pc !== 32'hFFFF_FFFC || if_next_pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h/%h want fffffffc/0", if_pc, if_next_pc); end
    tick();
    n_cmp++; if (im_req !== 1'b1 || im_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next got %b/%h want 1/0", im_req, im_addr); end
  endtask

  task automatic test_reset_flush();
    redirect_valid = 1'b1;
    redirect_addr = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (im_req !== 1'b0 || if_valid !== 1'b0 || im_addr !== 32'h0) begin n_err++; $display("FAIL rstflush got req %b v%b addr %h want 0 0 0", im_req, if_valid, im_addr); end
    tick();
    rst = 1'b0;
    ack(32'hAB0A_B0AB);
    n_cmp++; if (if_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h0) begin n_err++; $display("FAIL late_ack got v%b req %b addr %h want 0 1 0", if_valid, im_req, im_addr); end
    ack(32'h5555_0000);
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h5555_0000) begin n_err++; $display("FAIL rst_refetch got v%b pc %h instr %h want 1 0 55550000", if_valid, if_pc, if_instr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_flush();
    test_redirect_ack();
    test_wrap();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
